// File: rtl/core_dmem_sram_ctrl_if.sv
// Data-memory request/response bus between the execute-stage LSU (master)
// and the SRAM-backed data-memory controller (slave).
interface core_dmem_sram_ctrl_if;
    logic        dmem_req;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_strb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_err;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
        input  dmem_gnt, dmem_err, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
        output dmem_gnt, dmem_err, dmem_rdata
    );
endinterface

// File: rtl/core_dmem_sram_ctrl.sv
// Data-memory slave: req/gnt front end onto a 1-cycle-latency SRAM with wait states
// and address range checking. Optional perf counters: define CORE_DMEM_SRAM_PERF_EN.
module core_dmem_sram_ctrl #(
    parameter logic [63:0] MEM_BASE    = 64'h0000_0000_0001_0000,
    parameter int          MEM_SIZE    = 65536,
    parameter int          WAIT_CYCLES = 0,
    localparam int         AW          = $clog2(MEM_SIZE / 8)
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    core_dmem_sram_ctrl_if.slave dmem,
    output logic                 sram_cen,
    output logic                 sram_wen,
    output logic [AW-1:0]        sram_addr,
    output logic [7:0]           sram_wstrb,
    output logic [63:0]          sram_wdata,
    input  logic [63:0]          sram_rdata
`ifdef CORE_DMEM_SRAM_PERF_EN
    ,
    output logic [31:0]          perf_loads,
    output logic [31:0]          perf_stores,
    output logic [31:0]          perf_errors
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [64:0] BASE65  = {1'b0, MEM_BASE};
    localparam logic [64:0] LIMIT65 = BASE65 + 65'(MEM_SIZE);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cntNext;
    logic        r_err;
    logic        r_rd;
    logic        w_gnt;
    logic        w_inRange;
    logic [64:0] w_addr65;

    // 65-bit compare so a window ending exactly at 2^64 does not wrap to zero
    assign w_addr65  = {1'b0, dmem.dmem_addr};
    assign w_inRange = (w_addr65 >= BASE65) && (w_addr65 < LIMIT65);

    assign sram_addr  = AW'((dmem.dmem_addr - MEM_BASE) >> 3);
    assign sram_wdata = dmem.dmem_wdata;
    assign sram_wstrb = dmem.dmem_strb;
    assign sram_wen   = dmem.dmem_wen;
    assign sram_cen   = w_gnt && w_inRange && (!dmem.dmem_wen || (|dmem.dmem_strb));

    assign dmem.dmem_gnt   = w_gnt;
    assign dmem.dmem_err   = (r_state == RESP) ? r_err : 1'b0;
    assign dmem.dmem_rdata = ((r_state == RESP) && r_rd) ? sram_rdata : 64'h0;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
            if (w_gnt) begin
                r_err <= !w_inRange;
                r_rd  <= w_inRange && !dmem.dmem_wen;
            end
        end
    end

    // Grant is held off while reset is asserted so no SRAM cycle starts during reset
    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        w_gnt       = 1'b0;
        if (!g_resetn) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dmem.dmem_req) begin
                        if (WAIT_CYCLES == 0) begin
                            w_gnt       = 1'b1;
                            w_nextState = RESP;
                        end else begin
                            w_cntNext   = 4'(WAIT_CYCLES - 1);
                            w_nextState = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!dmem.dmem_req) begin
                        w_nextState = IDLE;
                    end else if (r_cnt == 4'd0) begin
                        w_gnt       = 1'b1;
                        w_nextState = RESP;
                    end else begin
                        w_cntNext = r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

`ifdef CORE_DMEM_SRAM_PERF_EN
    logic [31:0] r_perfLoads;
    logic [31:0] r_perfStores;
    logic [31:0] r_perfErrors;

    // Saturating event counters, sampled on every grant
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            r_perfLoads  <= 32'd0;
            r_perfStores <= 32'd0;
            r_perfErrors <= 32'd0;
        end else if (w_gnt) begin
            if (w_inRange && !dmem.dmem_wen && (r_perfLoads != 32'hFFFF_FFFF))
                r_perfLoads <= r_perfLoads + 32'd1;
            if (w_inRange && dmem.dmem_wen && (r_perfStores != 32'hFFFF_FFFF))
                r_perfStores <= r_perfStores + 32'd1;
            if (!w_inRange && (r_perfErrors != 32'hFFFF_FFFF))
                r_perfErrors <= r_perfErrors + 32'd1;
        end
    end

    assign perf_loads  = r_perfLoads;
    assign perf_stores = r_perfStores;
    assign perf_errors = r_perfErrors;
`endif

endmodule

// File: tb/tb_core_dmem_sram_ctrl.sv
// Directed bench: one controller with no wait states, one with three, each on its own SRAM model.
module tb_core_dmem_sram_ctrl;

    localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
    localparam int          SIZE = 65536;
    localparam int          AW   = 13;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 g_clk = ~g_clk;

    core_dmem_sram_ctrl_if bus0 ();
    core_dmem_sram_ctrl_if bus3 ();

    logic          sramCen0, sramWen0, sramCen3, sramWen3;
    logic [AW-1:0] sramAddr0, sramAddr3;
    logic [7:0]    sramWstrb0, sramWstrb3;
    logic [63:0]   sramWdata0, sramWdata3, sramRdata0, sramRdata3;
    logic [63:0]   mem0 [0:(SIZE/8)-1];
    logic [63:0]   mem3 [0:(SIZE/8)-1];

`ifdef CORE_DMEM_SRAM_PERF_EN
    logic [31:0] perfLoads0, perfStores0, perfErrors0;
    logic [31:0] perfLoads3, perfStores3, perfErrors3;
`endif

    core_dmem_sram_ctrl #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .WAIT_CYCLES(0)) u_dut0 (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem(bus0),
        .sram_cen(sramCen0), .sram_wen(sramWen0), .sram_addr(sramAddr0),
        .sram_wstrb(sramWstrb0), .sram_wdata(sramWdata0), .sram_rdata(sramRdata0)
`ifdef CORE_DMEM_SRAM_PERF_EN
        , .perf_loads(perfLoads0), .perf_stores(perfStores0), .perf_errors(perfErrors0)
`endif
    );

    core_dmem_sram_ctrl #(.MEM_BASE(BASE), .MEM_SIZE(SIZE), .WAIT_CYCLES(3)) u_dut3 (
        .g_clk(g_clk), .g_resetn(g_resetn), .dmem(bus3),
        .sram_cen(sramCen3), .sram_wen(sramWen3), .sram_addr(sramAddr3),
        .sram_wstrb(sramWstrb3), .sram_wdata(sramWdata3), .sram_rdata(sramRdata3)
`ifdef CORE_DMEM_SRAM_PERF_EN
        , .perf_loads(perfLoads3), .perf_stores(perfStores3), .perf_errors(perfErrors3)
`endif
    );

    // Single-port synchronous SRAM models with byte write masks and 1-cycle read latency
    always @(posedge g_clk) begin
        if (sramCen0) begin
            if (sramWen0) begin
                for (int b = 0; b < 8; b++)
                    if (sramWstrb0[b]) mem0[sramAddr0][8*b +: 8] <= sramWdata0[8*b +: 8];
            end else begin
                sramRdata0 <= mem0[sramAddr0];
            end
        end
    end

    always @(posedge g_clk) begin
        if (sramCen3) begin
            if (sramWen3) begin
                for (int b = 0; b < 8; b++)
                    if (sramWstrb3[b]) mem3[sramAddr3][8*b +: 8] <= sramWdata3[8*b +: 8];
            end else begin
                sramRdata3 <= mem3[sramAddr3];
            end
        end
    end

    // One WAIT_CYCLES=0 transaction; starts and ends at posedge+1 with the FSM idle
    task automatic applyStimulus(input logic [63:0] addr, input logic wen, input logic [7:0] strb,
                                 input logic [63:0] wdata, output logic gnt, output logic cen,
                                 output logic sWen, output logic [AW-1:0] sAddr,
                                 output logic err, output logic [63:0] rdata);
        bus0.dmem_addr  = addr;
        bus0.dmem_wen   = wen;
        bus0.dmem_strb  = strb;
        bus0.dmem_wdata = wdata;
        bus0.dmem_req   = 1'b1;
        @(negedge g_clk);
        gnt   = bus0.dmem_gnt;
        cen   = sramCen0;
        sWen  = sramWen0;
        sAddr = sramAddr0;
        @(posedge g_clk); #1;
        bus0.dmem_req = 1'b0;
        err   = bus0.dmem_err;
        rdata = bus0.dmem_rdata;
        @(posedge g_clk); #1;
    endtask

    task automatic test_reset();
        bus0.dmem_req = 1'b0; bus0.dmem_addr = '0; bus0.dmem_wen = 1'b0;
        bus0.dmem_strb = '0; bus0.dmem_wdata = '0;
        bus3.dmem_req = 1'b0; bus3.dmem_addr = '0; bus3.dmem_wen = 1'b0;
        bus3.dmem_strb = '0; bus3.dmem_wdata = '0;
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        #1;
        bus0.dmem_req = 1'b1;
        @(negedge g_clk);
        checks++;
        if (bus0.dmem_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt: got %b want 0", bus0.dmem_gnt); end
        checks++;
        if (sramCen0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_cen: got %b want 0", sramCen0); end
        checks++;
        if (bus0.dmem_err !== 1'b0 || bus0.dmem_rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL rst_resp: err=%b rdata=%h want 0/0", bus0.dmem_err, bus0.dmem_rdata);
        end
`ifdef CORE_DMEM_SRAM_PERF_EN
        checks++;
        if (perfLoads0 !== 32'd0 || perfStores0 !== 32'd0 || perfErrors0 !== 32'd0) begin
            errors++; $display("[TB] FAIL rst_perf: got %0d/%0d/%0d want 0/0/0", perfLoads0, perfStores0, perfErrors0);
        end
`endif
        @(posedge g_clk); #1;
        bus0.dmem_req = 1'b0;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
    endtask

    task automatic test_write_read();
        logic gnt, cen, sWen, err;
        logic [AW-1:0] sAddr;
        logic [63:0] rdata;
        applyStimulus(BASE + 64'd8, 1'b1, 8'hFF, 64'hDEAD_BEEF_0123_4567, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (gnt !== 1'b1 || cen !== 1'b1 || sWen !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_gnt_cen_wen: got %b%b%b want 111", gnt, cen, sWen);
        end
        checks++;
        if (sAddr !== 13'd1) begin errors++; $display("[TB] FAIL wr_addr: got %0d want 1", sAddr); end
        checks++;
        if (err !== 1'b0 || rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL wr_resp: err=%b rdata=%h want 0/0", err, rdata);
        end
        applyStimulus(BASE + 64'd8, 1'b0, 8'h00, 64'h0, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (gnt !== 1'b1 || cen !== 1'b1 || sWen !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_gnt_cen_wen: got %b%b%b want 110", gnt, cen, sWen);
        end
        checks++;
        if (err !== 1'b0 || rdata !== 64'hDEAD_BEEF_0123_4567) begin
            errors++; $display("[TB] FAIL rd_resp: err=%b rdata=%h want 0/deadbeef01234567", err, rdata);
        end
    endtask

    task automatic test_byte_write();
        logic gnt, cen, sWen, err;
        logic [AW-1:0] sAddr;
        logic [63:0] rdata;
        applyStimulus(BASE + 64'd8, 1'b1, 8'h10, 64'h0000_00AB_0000_0000, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (gnt !== 1'b1 || cen !== 1'b1) begin errors++; $display("[TB] FAIL bw_gnt_cen: got %b%b want 11", gnt, cen); end
        applyStimulus(BASE + 64'd8, 1'b0, 8'h00, 64'h0, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (rdata !== 64'hDEAD_BEAB_0123_4567) begin
            errors++; $display("[TB] FAIL bw_rdata: got %h want deadbeab01234567", rdata);
        end
        // Zero-strobe write: granted, no SRAM cycle, word unchanged
        applyStimulus(BASE + 64'd8, 1'b1, 8'h00, 64'h1111_1111_1111_1111, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (gnt !== 1'b1 || cen !== 1'b0 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL zstrb: gnt=%b cen=%b err=%b want 1/0/0", gnt, cen, err);
        end
    endtask

    task automatic test_range_error();
        logic gnt, cen, sWen, err;
        logic [AW-1:0] sAddr;
        logic [63:0] rdata;
        applyStimulus(BASE + 64'(SIZE), 1'b0, 8'h00, 64'h0, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (gnt !== 1'b1 || cen !== 1'b0) begin errors++; $display("[TB] FAIL oor_hi_gnt_cen: got %b%b want 10", gnt, cen); end
        checks++;
        if (err !== 1'b1 || rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL oor_hi_resp: err=%b rdata=%h want 1/0", err, rdata);
        end
        applyStimulus(BASE - 64'd8, 1'b0, 8'h00, 64'h0, gnt, cen, sWen, sAddr, err, rdata);
        checks++;
        if (gnt !== 1'b1 || cen !== 1'b0) begin errors++; $display("[TB] FAIL oor_lo_gnt_cen: got %b%b want 10", gnt, cen); end
        checks++;
        if (err !== 1'b1 || rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL oor_lo_resp: err=%b rdata=%h want 1/0", err, rdata);
        end
    endtask

    task automatic test_back_to_back();
        bus0.dmem_addr = BASE + 64'd8;
        bus0.dmem_wen  = 1'b0;
        bus0.dmem_strb = 8'h00;
        bus0.dmem_req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge g_clk);
            checks++;
            if (bus0.dmem_gnt !== ((i % 2) == 0)) begin
                errors++; $display("[TB] FAIL b2b_gnt[%0d]: got %b want %b", i, bus0.dmem_gnt, (i % 2) == 0);
            end
            if ((i % 2) == 1) begin
                checks++;
                if (bus0.dmem_rdata !== 64'hDEAD_BEAB_0123_4567) begin
                    errors++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want deadbeab01234567", i, bus0.dmem_rdata);
                end
            end
            @(posedge g_clk); #1;
        end
        bus0.dmem_req = 1'b0;
    endtask

    task automatic test_wait_states();
        // Held request: grant on the 4th cycle of req
        bus3.dmem_addr = BASE + 64'd16; bus3.dmem_wen = 1'b1;
        bus3.dmem_strb = 8'hFF; bus3.dmem_wdata = 64'h0123_4567_89AB_CDEF;
        bus3.dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            checks++;
            if (bus3.dmem_gnt !== (i == 3) || sramCen3 !== (i == 3)) begin
                errors++; $display("[TB] FAIL ws_wr[%0d]: gnt=%b cen=%b want %b", i, bus3.dmem_gnt, sramCen3, i == 3);
            end
            @(posedge g_clk); #1;
        end
        bus3.dmem_req = 1'b0;
        @(posedge g_clk); #1;
        bus3.dmem_wen = 1'b0;
        bus3.dmem_req = 1'b1;
        repeat (4) @(posedge g_clk);
        #1;
        bus3.dmem_req = 1'b0;
        checks++;
        if (bus3.dmem_rdata !== 64'h0123_4567_89AB_CDEF || bus3.dmem_err !== 1'b0) begin
            errors++; $display("[TB] FAIL ws_rd: rdata=%h err=%b want 0123456789abcdef/0", bus3.dmem_rdata, bus3.dmem_err);
        end
        @(posedge g_clk); #1;
        // Flush: request dropped after two cycles produces nothing
        bus3.dmem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus3.dmem_req = 1'b0;
            @(negedge g_clk);
            checks++;
            if (bus3.dmem_gnt !== 1'b0 || sramCen3 !== 1'b0 || bus3.dmem_err !== 1'b0) begin
                errors++; $display("[TB] FAIL ws_flush[%0d]: gnt=%b cen=%b err=%b want 0/0/0", i, bus3.dmem_gnt, sramCen3, bus3.dmem_err);
            end
            @(posedge g_clk); #1;
        end
    endtask

`ifdef CORE_DMEM_SRAM_PERF_EN
    task automatic test_perf();
        checks++;
        if (perfLoads0 !== 32'd5 || perfStores0 !== 32'd3 || perfErrors0 !== 32'd2) begin
            errors++; $display("[TB] FAIL perf: got %0d/%0d/%0d want 5/3/2", perfLoads0, perfStores0, perfErrors0);
        end
    endtask
`endif

    task automatic test_reset_midflight();
        // Reset while waiting: the wait count restarts after release
        bus3.dmem_addr = BASE + 64'd16; bus3.dmem_wen = 1'b0; bus3.dmem_req = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        @(negedge g_clk);
        checks++;
        if (bus3.dmem_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_gnt: got %b want 0", bus3.dmem_gnt); end
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            checks++;
            if (bus3.dmem_gnt !== (i == 3)) begin
                errors++; $display("[TB] FAIL rst_wait_regnt[%0d]: got %b want %b", i, bus3.dmem_gnt, i == 3);
            end
            @(posedge g_clk); #1;
        end
        bus3.dmem_req = 1'b0;
        // Reset during an error response: nothing follows it
        bus0.dmem_addr = BASE + 64'(SIZE); bus0.dmem_wen = 1'b0; bus0.dmem_req = 1'b1;
        @(posedge g_clk); #1;
        g_resetn = 1'b0;
        bus0.dmem_req = 1'b0;
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        checks++;
        if (bus0.dmem_gnt !== 1'b0 || bus0.dmem_err !== 1'b0 || bus0.dmem_rdata !== 64'h0) begin
            errors++; $display("[TB] FAIL rst_resp_after: gnt=%b err=%b rdata=%h want 0/0/0", bus0.dmem_gnt, bus0.dmem_err, bus0.dmem_rdata);
        end
        @(posedge g_clk); #1;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_range_error();
        test_back_to_back();
        test_wait_states();
`ifdef CORE_DMEM_SRAM_PERF_EN
        test_perf();
`endif
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
